// File: rtl/median_pkg.sv
// Shared widths, window geometry and the sample type for the running-median datapath.
package median_pkg;
    localparam int W   = 16;
    localparam int WIN = 7;
    localparam int MID = (WIN - 1) / 2;

    typedef logic [W-1:0] sample_t;
endpackage

// File: rtl/median_filter_sort_cell.sv
// One entry of the sorted store: removes one copy of the outgoing sample and inserts the incoming one.
module sort_cell
    import median_pkg::*;
#(
    parameter int W = median_pkg::W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] new_i,
    input  logic [W-1:0] old_i,
    input  logic [W-1:0] left_i,
    input  logic [W-1:0] right_i,
    input  logic         gt_left_i,
    input  logic         gt_right_i,
    input  logic         rem_i,
    output logic [W-1:0] val_o,
    output logic [W-1:0] val_d_o,
    output logic         gt_o,
    output logic         rem_o
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;
    logic         ge_old;
    logic         left_gt;
    logic         self_le;

    assign gt_o   = val_q > new_i;
    assign ge_old = val_q >= old_i;
    assign rem_o  = rem_i | ge_old;

    // rem_i set: the removed entry sits below us, so the compacted view shifts down by one.
    always_comb begin
        left_gt = rem_i ? gt_o : gt_left_i;
        self_le = rem_o ? !gt_right_i : !gt_o;
        val_d   = new_i;
        if (left_gt) begin
            val_d = rem_i ? val_q : left_i;
        end else if (self_le) begin
            val_d = rem_o ? right_i : val_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o   = val_q;
    assign val_d_o = val_d;

endmodule

// File: rtl/median_filter_top.sv
// Running median over the last WIN samples: history FIFO, sorted cell array and a registered median.
module median_filter_top
    import median_pkg::*;
#(
    parameter int W   = median_pkg::W,
    parameter int WIN = median_pkg::WIN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] X,
    output logic [W-1:0] median
);

    localparam int MID_IDX = (WIN - 1) / 2;

    logic [W-1:0] hist_q [WIN];
    logic [W-1:0] median_q;

    logic [W-1:0] cell_val [WIN];
    logic [W-1:0] cell_nxt [WIN];
    logic         cell_gt  [WIN];
    logic         rem_c    [WIN+1];

    // Padded neighbour views: below index 0 nothing is greater, above the top everything is.
    logic [W-1:0] val_pad [WIN+2];
    logic         gt_pad  [WIN+2];

    always_comb begin
        val_pad[0]     = '0;
        gt_pad[0]      = 1'b0;
        val_pad[WIN+1] = '0;
        gt_pad[WIN+1]  = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            val_pad[i+1] = cell_val[i];
            gt_pad[i+1]  = cell_gt[i];
        end
    end

    assign rem_c[0] = 1'b0;

    for (genvar g = 0; g < WIN; g++) begin : g_cell
        sort_cell #(.W(W)) u_cell (
            .clk       (clk),
            .reset     (reset),
            .new_i     (X),
            .old_i     (hist_q[0]),
            .left_i    (val_pad[g]),
            .right_i   (val_pad[g+2]),
            .gt_left_i (gt_pad[g]),
            .gt_right_i(gt_pad[g+2]),
            .rem_i     (rem_c[g]),
            .val_o     (cell_val[g]),
            .val_d_o   (cell_nxt[g]),
            .gt_o      (cell_gt[g]),
            .rem_o     (rem_c[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WIN; i++) begin
                hist_q[i] <= '0;
            end
            median_q <= '0;
        end else begin
            for (int i = 0; i < WIN - 1; i++) begin
                hist_q[i] <= hist_q[i+1];
            end
            hist_q[WIN-1] <= X;
            median_q      <= cell_nxt[MID_IDX];
        end
    end

    assign median = median_q;

endmodule

// File: tb/tb_median_filter_top.sv
// Directed vectors for the running median; a scoreboard queue feeds a decoupled output monitor.
module tb_median_filter_top;

    logic        clk;
    logic        reset;
    logic [15:0] X;
    logic [15:0] median;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q  [$];
    string       name_q [$];
    logic [15:0] mon_exp;
    string       mon_name;

    median_filter_top #(.W(16), .WIN(7)) dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .median(median)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each queued entry is the median expected right after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            total++;
            if (median !== mon_exp) begin
                bad++;
                $display("FAIL %s: median=%0d expected=%0d", mon_name, median, mon_exp);
            end
        end
    end

    task automatic step(input logic r, input logic [15:0] x, input logic [15:0] e, input string nm);
        @(negedge clk);
        reset = r;
        X     = x;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        reset = 1'b0;
        X     = 16'd0;

        step(1'b0, 16'd1234, 16'd0, "reset0");
        step(1'b0, 16'd1234, 16'd0, "reset1");

        step(1'b1, 16'd64, 16'd0,  "warm64");
        step(1'b1, 16'd62, 16'd0,  "warm62");
        step(1'b1, 16'd76, 16'd0,  "warm76a");
        step(1'b1, 16'd76, 16'd62, "warm76b");

        step(1'b1, 16'd121, 16'd64, "full121");
        step(1'b1, 16'd79,  16'd76, "full79");
        step(1'b1, 16'd83,  16'd76, "full83");
        step(1'b1, 16'd80,  16'd79, "dup80");
        step(1'b1, 16'd48,  16'd79, "dup48");
        step(1'b1, 16'd88,  16'd80, "dup88");

        step(1'b0, 16'd999, 16'd0, "midreset");
        step(1'b1, 16'd10, 16'd0,  "ten1");
        step(1'b1, 16'd10, 16'd0,  "ten2");
        step(1'b1, 16'd10, 16'd0,  "ten3");
        step(1'b1, 16'd10, 16'd10, "ten4");

        step(1'b1, 16'd500, 16'd10, "eq1");
        step(1'b1, 16'd500, 16'd10, "eq2");
        step(1'b1, 16'd500, 16'd10, "eq3");
        for (int i = 4; i <= 14; i++) begin
            step(1'b1, 16'd500, 16'd500, $sformatf("eq%0d", i));
        end

        step(1'b1, 16'hFFFF, 16'd500,  "hi1");
        step(1'b1, 16'hFFFF, 16'd500,  "hi2");
        step(1'b1, 16'hFFFF, 16'd500,  "hi3");
        step(1'b1, 16'hFFFF, 16'hFFFF, "hi4");
        step(1'b1, 16'h0000, 16'hFFFF, "lo1");
        step(1'b1, 16'h0000, 16'hFFFF, "lo2");
        step(1'b1, 16'h0000, 16'hFFFF, "lo3");
        step(1'b1, 16'h0000, 16'h0000, "lo4");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
